// File: rtl/decode_stage.sv
// Registered instruction-decode stage with a 2-entry skid buffer and a wrap-around decode counter.
// Optional opcode legality flag enabled by defining DECODE_ILLEGAL_CHECK_EN.
module decode_stage #(
  parameter int         REG_AW     = 3,
  parameter int         DATA_W     = 8,
  parameter int         CNT_W      = 16,
  parameter logic [7:0] OPCODE_MAX = 8'h0B
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                FLUSH,
  input  logic [31:0]         IN_INSTR,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [7:0]          OPCODE,
  output logic [REG_AW-1:0]   WRITE_REG,
  output logic [REG_AW-1:0]   READ_REG1,
  output logic [REG_AW-1:0]   READ_REG2,
  output logic [DATA_W-1:0]   IMMEDIATE,
  output logic [7:0]          BRANCH_OFFSET,
  output logic [CNT_W-1:0]    DECODE_COUNT
`ifdef DECODE_ILLEGAL_CHECK_EN
  ,
  output logic                ILLEGAL
`endif
);

  typedef struct packed {
    logic [7:0]               opcode;
    logic [REG_AW-1:0]        write_reg;
    logic [REG_AW-1:0]        read_reg1;
    logic [REG_AW-1:0]        read_reg2;
    logic signed [DATA_W-1:0] immediate;
    logic [7:0]               branch_offset;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic                     illegal;
`endif
  } fields_t;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [7:0] b);
    return DATA_W'(b);
  endfunction

  function automatic fields_t decode(input logic [31:0] instr);
    fields_t f;
    f.opcode        = instr[31:24];
    f.write_reg     = instr[16 +: REG_AW];
    f.read_reg1     = instr[8 +: REG_AW];
    f.read_reg2     = instr[0 +: REG_AW];
    f.immediate     = sext_imm(instr[7:0]);
    f.branch_offset = instr[23:16];
`ifdef DECODE_ILLEGAL_CHECK_EN
    f.illegal       = (instr[31:24] > OPCODE_MAX);
`endif
    return f;
  endfunction

  logic             in_fire;
  logic             out_fire;
  fields_t          in_dec;

  logic             o_valid_q, o_valid_d;
  fields_t          o_data_q,  o_data_d;
  logic             s_valid_q, s_valid_d;
  fields_t          s_data_q,  s_data_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] count_q,   count_d;

  // Stage boundary: input handshake -> decode -> output/skid registers
  always_comb begin
    in_fire    = IN_VALID & in_ready_q;
    out_fire   = o_valid_q & OUT_READY;
    in_dec     = decode(IN_INSTR);
    o_valid_d  = o_valid_q;
    o_data_d   = o_data_q;
    s_valid_d  = s_valid_q;
    s_data_d   = s_data_q;
    count_d    = count_q + CNT_W'(out_fire);
    if (FLUSH) begin
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!o_valid_q || OUT_READY) begin
      if (s_valid_q) begin
        o_data_d  = s_data_q;
        o_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (in_fire) begin
        o_data_d  = in_dec;
        o_valid_d = 1'b1;
      end else begin
        o_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      s_data_d  = in_dec;
      s_valid_d = 1'b1;
    end
    // Ready is registered so OUT_READY never reaches IN_READY combinationally.
    in_ready_d = !s_valid_d;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b0;
      count_q    <= '0;
    end else begin
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
      count_q    <= count_d;
    end
  end

  // Skid payload is qualified by s_valid_q, so it needs no reset.
  always_ff @(posedge CLK) begin
    s_data_q <= s_data_d;
  end

  assign IN_READY      = in_ready_q;
  assign OUT_VALID     = o_valid_q;
  assign OPCODE        = o_data_q.opcode;
  assign WRITE_REG     = o_data_q.write_reg;
  assign READ_REG1     = o_data_q.read_reg1;
  assign READ_REG2     = o_data_q.read_reg2;
  assign IMMEDIATE     = o_data_q.immediate;
  assign BRANCH_OFFSET = o_data_q.branch_offset;
  assign DECODE_COUNT  = count_q;
`ifdef DECODE_ILLEGAL_CHECK_EN
  assign ILLEGAL       = o_data_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage (REG_AW=4, DATA_W=16, CNT_W=2); checks ILLEGAL when DECODE_ILLEGAL_CHECK_EN is defined.
module tb_decode_stage;

  logic        CLK;
  logic        RESET_N;
  logic        FLUSH;
  logic [31:0] IN_INSTR;
  logic        IN_VALID;
  logic        IN_READY;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [7:0]  OPCODE;
  logic [3:0]  WRITE_REG;
  logic [3:0]  READ_REG1;
  logic [3:0]  READ_REG2;
  logic [15:0] IMMEDIATE;
  logic [7:0]  BRANCH_OFFSET;
  logic [1:0]  DECODE_COUNT;
`ifdef DECODE_ILLEGAL_CHECK_EN
  logic        ILLEGAL;
`endif

  decode_stage #(.REG_AW(4), .DATA_W(16), .CNT_W(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH),
    .IN_INSTR(IN_INSTR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OPCODE(OPCODE), .WRITE_REG(WRITE_REG), .READ_REG1(READ_REG1),
    .READ_REG2(READ_REG2), .IMMEDIATE(IMMEDIATE),
    .BRANCH_OFFSET(BRANCH_OFFSET), .DECODE_COUNT(DECODE_COUNT)
`ifdef DECODE_ILLEGAL_CHECK_EN
    , .ILLEGAL(ILLEGAL)
`endif
  );

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  wr;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [15:0] imm;
    logic [7:0]  bo;
    logic        ill;
  } exp_t;

  exp_t       q[$];
  logic [1:0] exp_count;
  int         n_checks;
  int         n_fail;
  bit         rdy_exempt;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    e.op  = i[31:24];
    e.wr  = i[19:16];
    e.r1  = i[11:8];
    e.r2  = i[3:0];
    e.imm = i[7] ? {8'hFF, i[7:0]} : {8'h00, i[7:0]};
    e.bo  = i[23:16];
    e.ill = (i[31:24] > 8'h0B);
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the scoreboard away from the active edge.
  always @(negedge CLK) begin
    if (!RESET_N) begin
      q.delete();
      exp_count = 2'd0;
    end else begin
      exp_t e;
      if (!rdy_exempt) check_val("in_ready", 64'(IN_READY), 64'(q.size() < 2));
      check_val("out_valid", 64'(OUT_VALID), 64'(q.size() > 0));
      check_val("count", 64'(DECODE_COUNT), 64'(exp_count));
      if (OUT_VALID && q.size() > 0) begin
        e = q[0];
        check_val("opcode", 64'(OPCODE), 64'(e.op));
        check_val("write_reg", 64'(WRITE_REG), 64'(e.wr));
        check_val("read_reg1", 64'(READ_REG1), 64'(e.r1));
        check_val("read_reg2", 64'(READ_REG2), 64'(e.r2));
        check_val("immediate", 64'(IMMEDIATE), 64'(e.imm));
        check_val("branch_off", 64'(BRANCH_OFFSET), 64'(e.bo));
`ifdef DECODE_ILLEGAL_CHECK_EN
        check_val("illegal", 64'(ILLEGAL), 64'(e.ill));
`endif
      end
      if (OUT_VALID && OUT_READY) begin
        if (q.size() > 0) void'(q.pop_front());
        exp_count = exp_count + 2'd1;
      end
      if (FLUSH) q.delete();
      else if (IN_VALID && IN_READY) q.push_back(model(IN_INSTR));
    end
  end

  task automatic send(input logic [31:0] instr, output int cyc);
    bit acc;
    cyc      = 0;
    acc      = 1'b0;
    IN_INSTR = instr;
    IN_VALID = 1'b1;
    do begin
      acc = IN_READY;
      @(posedge CLK);
      #1;
      cyc++;
    end while (!acc && cyc < 20);
    IN_VALID = 1'b0;
    check_val("send_accept", 64'(acc), 64'(1));
  endtask

  initial begin
    int         c;
    logic [1:0] base;
    n_checks   = 0;
    n_fail     = 0;
    rdy_exempt = 1'b1;
    exp_count  = 2'd0;
    RESET_N    = 1'b0;
    FLUSH      = 1'b0;
    IN_VALID   = 1'b0;
    IN_INSTR   = '0;
    OUT_READY  = 1'b0;

    #2;
    check_val("rst_out_valid", 64'(OUT_VALID), 64'(0));
    check_val("rst_in_ready", 64'(IN_READY), 64'(0));
    check_val("rst_count", 64'(DECODE_COUNT), 64'(0));
    check_val("rst_opcode", 64'(OPCODE), 64'(0));
    check_val("rst_imm", 64'(IMMEDIATE), 64'(0));
    @(posedge CLK); @(posedge CLK); #1;
    RESET_N = 1'b1;
    check_val("rel_in_ready0", 64'(IN_READY), 64'(0));
    @(posedge CLK); #1;
    rdy_exempt = 1'b0;
    check_val("rel_in_ready1", 64'(IN_READY), 64'(1));

    // Basic decode
    OUT_READY = 1'b1;
    send(32'h02050301, c);
    check_val("basic_valid", 64'(OUT_VALID), 64'(1));
    check_val("basic_op", 64'(OPCODE), 64'(8'h02));
    check_val("basic_wr", 64'(WRITE_REG), 64'(4'd5));
    check_val("basic_r1", 64'(READ_REG1), 64'(4'd3));
    check_val("basic_r2", 64'(READ_REG2), 64'(4'd1));
    check_val("basic_imm", 64'(IMMEDIATE), 64'(16'h0001));
    check_val("basic_bo", 64'(BRANCH_OFFSET), 64'(8'h05));
    @(posedge CLK); #1;
    check_val("basic_count", 64'(DECODE_COUNT), 64'(1));

    // Sign extension, register fields, back-to-back throughput
    send(32'h010200F6, c);
    check_val("sext_imm", 64'(IMMEDIATE), 64'(16'hFFF6));
    send(32'h000F0E0D, c);
    check_val("tput_cycles", 64'(c), 64'(1));
    check_val("reg_wr", 64'(WRITE_REG), 64'(4'hF));
    check_val("reg_r1", 64'(READ_REG1), 64'(4'hE));
    check_val("reg_r2", 64'(READ_REG2), 64'(4'hD));
    send(32'h00FFFEFD, c);
    check_val("tput_cycles2", 64'(c), 64'(1));
    check_val("reg_hi_wr", 64'(WRITE_REG), 64'(4'hF));
    check_val("reg_hi_r2", 64'(READ_REG2), 64'(4'hD));
    check_val("pos_imm", 64'(IMMEDIATE), 64'(16'hFFFD));
    @(posedge CLK); #1;

    // Back-pressure: A into O, B into skid, C held
    OUT_READY = 1'b0;
    send(32'h03010203, c);
    send(32'h04020304, c);
    check_val("bp_full_ready", 64'(IN_READY), 64'(0));
    IN_INSTR = 32'h05030405;
    IN_VALID = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
      check_val("bp_hold_op", 64'(OPCODE), 64'(8'h03));
      check_val("bp_hold_ready", 64'(IN_READY), 64'(0));
    end
    base = exp_count;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    check_val("bp_seq_b", 64'(OPCODE), 64'(8'h04));
    check_val("bp_seq_b_vld", 64'(OUT_VALID), 64'(1));
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    check_val("bp_seq_c", 64'(OPCODE), 64'(8'h05));
    check_val("bp_seq_c_vld", 64'(OUT_VALID), 64'(1));
    @(posedge CLK); #1;
    check_val("bp_empty", 64'(OUT_VALID), 64'(0));
    check_val("bp_count", 64'(DECODE_COUNT), 64'(2'(base + 2'd3)));

    // Flush with O and skid full
    OUT_READY = 1'b0;
    send(32'h06000001, c);
    send(32'h07000002, c);
    IN_INSTR = 32'h08000003;
    IN_VALID = 1'b1;
    FLUSH    = 1'b1;
    base     = exp_count;
    @(posedge CLK); #1;
    FLUSH    = 1'b0;
    IN_VALID = 1'b0;
    check_val("flush_valid", 64'(OUT_VALID), 64'(0));
    check_val("flush_ready", 64'(IN_READY), 64'(1));
    check_val("flush_count", 64'(DECODE_COUNT), 64'(base));

    // Flush coinciding with out_fire and in_fire
    OUT_READY = 1'b1;
    send(32'h09000004, c);
    IN_INSTR = 32'h0A000005;
    IN_VALID = 1'b1;
    FLUSH    = 1'b1;
    base     = exp_count;
    @(posedge CLK); #1;
    FLUSH    = 1'b0;
    IN_VALID = 1'b0;
    check_val("flush2_valid", 64'(OUT_VALID), 64'(0));
    check_val("flush2_count", 64'(DECODE_COUNT), 64'(2'(base + 2'd1)));

    // Asynchronous reset with two instructions buffered
    OUT_READY = 1'b0;
    send(32'h0B110101, c);
    send(32'h0C220202, c);
    #2;
    RESET_N    = 1'b0;
    rdy_exempt = 1'b1;
    #1;
    check_val("arst_valid", 64'(OUT_VALID), 64'(0));
    check_val("arst_count", 64'(DECODE_COUNT), 64'(0));
    check_val("arst_ready", 64'(IN_READY), 64'(0));
    check_val("arst_opcode", 64'(OPCODE), 64'(0));
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    check_val("arst_rel_ready0", 64'(IN_READY), 64'(0));
    @(posedge CLK); #1;
    rdy_exempt = 1'b0;
    check_val("arst_rel_ready1", 64'(IN_READY), 64'(1));

    // Post-reset decode, illegal opcodes, counter wrap after 5 handshakes
    OUT_READY = 1'b1;
    send(32'h0C3412F0, c);
    check_val("post_rst_op", 64'(OPCODE), 64'(8'h0C));
    check_val("post_rst_imm", 64'(IMMEDIATE), 64'(16'hFFF0));
`ifdef DECODE_ILLEGAL_CHECK_EN
    check_val("illegal_0c", 64'(ILLEGAL), 64'(1));
`endif
    send(32'h0B000000, c);
`ifdef DECODE_ILLEGAL_CHECK_EN
    check_val("illegal_0b", 64'(ILLEGAL), 64'(0));
`endif
    send(32'h01000001, c);
    send(32'h02000002, c);
    send(32'h03000003, c);
    @(posedge CLK); #1;
    check_val("cnt_wrap", 64'(DECODE_COUNT), 64'(1));

    // Random traffic with occasional flushes
    repeat (300) begin
      IN_VALID  = 1'($urandom_range(0, 1));
      IN_INSTR  = $urandom;
      OUT_READY = ($urandom_range(0, 3) != 0);
      FLUSH     = ($urandom_range(0, 31) == 0);
      @(posedge CLK); #1;
    end
    IN_VALID  = 1'b0;
    FLUSH     = 1'b0;
    OUT_READY = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    check_val("drain_empty", 64'(OUT_VALID), 64'(0));
    @(negedge CLK); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode stage for the pipelined successor of the single-cycle CPU.
- Accepts 32-bit instructions over a valid/ready handshake and splits them into opcode, register addresses, immediate and branch offset.
- Presents the decoded fields, registered, to the register file and control unit.
- A 2-entry skid buffer absorbs back-pressure without bubbles. A wrap-around counter tracks decoded instructions.

Parameters:
- REG_AW, 3, register-address width (1..8); selects the low REG_AW bits of each register byte lane.
- DATA_W, 8, width of the sign-extended immediate (>= 8).
- CNT_W, 16, width of the decoded-instruction counter.
- OPCODE_MAX, 8'h0B, highest legal opcode (used only with the optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous flush of all buffered instructions.
- IN_INSTR  in  32  instruction word.
- IN_VALID  in  1  IN_INSTR valid.
- IN_READY  out  1  stage can accept.
- OUT_VALID  out  1  decoded fields valid.
- OUT_READY  in  1  consumer accepts.
- OPCODE  out  8  IN_INSTR[31:24].
- WRITE_REG  out  REG_AW  IN_INSTR[16 +: REG_AW].
- READ_REG1  out  REG_AW  IN_INSTR[8 +: REG_AW].
- READ_REG2  out  REG_AW  IN_INSTR[0 +: REG_AW].
- IMMEDIATE  out  DATA_W  IN_INSTR[7:0], sign-extended.
- BRANCH_OFFSET  out  8  IN_INSTR[23:16], raw.
- DECODE_COUNT  out  CNT_W  number of output handshakes, modulo 2^CNT_W.

Behaviour:
- Reset (RESET_N low, asynchronous): OUT_VALID=0, skid empty, all field outputs=0, DECODE_COUNT=0.
- While reset is asserted, IN_READY=0. IN_READY returns to 1 on the first cycle after deassertion.
- In-flight instructions are discarded when reset asserts mid-operation.
- Definitions: in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
- IN_READY = !skid_valid, driven directly from a register with no combinational path from OUT_READY.
- Storage: output register (O) and skid register (S), each holding the full decoded field set plus a valid bit. Fields are decoded on entry, so S holds decoded data.
- Update per rising edge, in priority order:
  - FLUSH=1: O.valid=0, S.valid=0. A same-cycle in_fire is dropped. DECODE_COUNT still increments if out_fire occurred that cycle.
  - O empty or out_fire:
    - If S valid: O<=S, S.valid<=0. A same-cycle in_fire cannot occur because IN_READY=0.
    - Else if in_fire: O<=decode(IN_INSTR).
    - Else: O.valid<=0.
  - O valid and !OUT_READY and in_fire: S<=decode(IN_INSTR).
- Latency: IN_INSTR accepted at edge N appears on outputs after edge N, when O was empty or draining.
- Throughput: 1 instruction/cycle sustained while OUT_READY=1.
- Ordering is strictly FIFO; no instruction is duplicated or lost except by FLUSH or reset.
- Field outputs hold their last value while OUT_VALID=0. They are not cleared, except by reset.
- Sign extension: IMMEDIATE = {{(DATA_W-8){IN_INSTR[7]}}, IN_INSTR[7:0]}.
- Register fields use the low REG_AW bits of bytes 2, 1 and 0; upper bits of those bytes are ignored.
- DECODE_COUNT increments by 1 on each out_fire, wrapping from 2^CNT_W-1 to 0. FLUSH does not clear it.

Optional Feature:
- Macro: DECODE_ILLEGAL_CHECK_EN.
- When defined:
  - Adds output ILLEGAL (1 bit, registered with the fields, reset 0).
  - ILLEGAL=1 when OPCODE > OPCODE_MAX.
  - Illegal instructions still flow through and are counted; downstream decides whether to trap.
- When undefined: no ILLEGAL port and no comparator logic.

Test Plan:
- Basic decode: IN_INSTR=32'h02050301, OUT_READY=1, defaults → next cycle OUT_VALID=1, OPCODE=8'h02, WRITE_REG=3'd5, READ_REG1=3'd3, READ_REG2=3'd1, IMMEDIATE=8'h01, BRANCH_OFFSET=8'h05, DECODE_COUNT=1 after handshake.
- Sign extension: DATA_W=16, IN_INSTR=32'h010200F6 → IMMEDIATE=16'hFFF6. REG_AW=4, IN_INSTR=32'h000F0E0D → WRITE_REG=4'hF, READ_REG1=4'hE, READ_REG2=4'hD.
- Back-pressure: OUT_READY=0, send A then B → IN_READY=0 after B, C held.
  - Raise OUT_READY → outputs A, B, C in order on consecutive cycles with no bubble.
  - DECODE_COUNT=3.
- Flush: O and S both full, FLUSH=1 with IN_VALID=1 → next cycle OUT_VALID=0, IN_READY=1, DECODE_COUNT unchanged.
- Reset mid-stream: assert RESET_N=0 asynchronously between edges with 2 instructions buffered → OUT_VALID=0 and DECODE_COUNT=0 immediately, IN_READY=0. After release, first accepted instruction is decoded normally.
- Counter wrap and illegal: CNT_W=2, 5 handshakes → DECODE_COUNT=1. With DECODE_ILLEGAL_CHECK_EN, opcode 8'h0C → ILLEGAL=1; opcode 8'h0B → ILLEGAL=0.
